// File: rtl/window_gen_3x3.sv
// window_gen_3x3
//   Streaming 3x3 neighbourhood generator with clamp-to-edge padding. Takes a
//   raster-order pixel stream and emits one 3x3 window per image pixel, in raster
//   order of the window centre. Two line buffers hold the previous two rows. After
//   the last pixel of a frame, a flush phase emits the remaining IMG_W+1 windows.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake, transfer when both are high
//   in_data             : input pixel, raster order
//   out_valid           : window outputs are valid this cycle
//   p00..p22            : window, pRC = pixel (row+R-1, col+C-1), clamped to the image
//   out_row/out_col     : centre coordinate of the current window
//   out_eof             : last window of the frame
module window_gen_3x3 #(
  parameter int unsigned IMG_W = 415,
  parameter int unsigned IMG_H = 738,
  parameter int unsigned DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  output logic                     out_valid,
  output logic [DW-1:0]            p00,
  output logic [DW-1:0]            p01,
  output logic [DW-1:0]            p02,
  output logic [DW-1:0]            p10,
  output logic [DW-1:0]            p11,
  output logic [DW-1:0]            p12,
  output logic [DW-1:0]            p20,
  output logic [DW-1:0]            p21,
  output logic [DW-1:0]            p22,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     out_eof
);

  localparam int unsigned RW  = $clog2(IMG_H);
  localparam int unsigned CW  = $clog2(IMG_W);
  // Input row counter runs to IMG_H+1 during flush (pseudo rows below the image).
  localparam int unsigned RIW = $clog2(IMG_H + 2);

  typedef enum logic [0:0] {StRun, StFlush} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic [RIW-1:0]   r_row;
  logic [CW-1:0]    r_col;

  // Line buffers: r_lb1 holds the row above the input row, r_lb2 the one above that.
  logic [DW-1:0]    r_lb1 [IMG_W];
  logic [DW-1:0]    r_lb2 [IMG_W];

  // Column stack: r_c0 is the most recently pushed column, r_c1 the one before.
  // Index 0 = top (oldest row), 2 = bottom (input row).
  logic [DW-1:0]    r_c0 [3];
  logic [DW-1:0]    r_c1 [3];

  logic             r_out_valid;
  logic             r_out_eof;
  logic [DW-1:0]    r_win [9];
  logic [RW-1:0]    r_out_row;
  logic [CW-1:0]    r_out_col;

  logic             w_flush;
  logic             w_step;
  logic             w_col0;
  logic             w_last_col;
  logic             w_last_in;
  logic             w_emit;
  logic             w_eof;
  logic             w_top_clamp;
  logic [DW-1:0]    w_new [3];
  logic [DW-1:0]    w_l [3];
  logic [DW-1:0]    w_m [3];
  logic [DW-1:0]    w_r [3];
  logic [RW-1:0]    w_crow;
  logic [CW-1:0]    w_ccol;

  always_comb begin
    w_flush    = (r_state == StFlush);
    // During flush the block steps through pseudo pixels below the image on its own.
    w_step     = w_flush || (in_valid && r_in_ready);
    w_col0     = (r_col == '0);
    w_last_col = (r_col == CW'(IMG_W - 1));
    w_last_in  = !w_flush && (r_row == RIW'(IMG_H - 1)) && w_last_col;
    w_eof      = w_flush && w_col0 && (r_row == RIW'(IMG_H + 1));
    // A window is due once linear input index IMG_W+1 has been reached.
    w_emit     = w_step && ((r_row >= RIW'(2)) || ((r_row == RIW'(1)) && !w_col0));

    // New column: rows (row-2, row-1, row); pseudo rows below the image clamp to the last.
    w_new[0] = r_lb2[r_col];
    w_new[1] = r_lb1[r_col];
    w_new[2] = w_flush ? r_lb1[r_col] : in_data;

    if (w_col0) begin
      // Input at column 0 completes the window at the end of the row two above:
      // centre is the stored column, right edge clamps onto it.
      for (int k = 0; k < 3; k++) begin
        w_l[k] = r_c1[k];
        w_m[k] = r_c0[k];
        w_r[k] = r_c0[k];
      end
      w_top_clamp = (r_row == RIW'(2));
      w_crow      = RW'(r_row - RIW'(2));
      w_ccol      = CW'(IMG_W - 1);
    end else begin
      for (int k = 0; k < 3; k++) begin
        w_l[k] = (r_col == CW'(1)) ? r_c0[k] : r_c1[k];
        w_m[k] = r_c0[k];
        w_r[k] = w_new[k];
      end
      w_top_clamp = (r_row == RIW'(1));
      w_crow      = RW'(r_row - RIW'(1));
      w_ccol      = r_col - CW'(1);
    end

    // Centre on row 0: the row above comes from stale buffer data, replace it.
    if (w_top_clamp) begin
      w_l[0] = w_l[1];
      w_m[0] = w_m[1];
      w_r[0] = w_r[1];
    end
  end

  // Control FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StRun;
      r_in_ready  <= 1'b1;
      r_row       <= '0;
      r_col       <= '0;
      r_out_valid <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      for (int k = 0; k < 9; k++) r_win[k] <= '0;
    end else begin
      r_out_valid <= w_emit;
      r_out_eof   <= w_emit && w_eof;
      if (w_emit) begin
        for (int k = 0; k < 3; k++) begin
          r_win[3*k]     <= w_l[k];
          r_win[3*k + 1] <= w_m[k];
          r_win[3*k + 2] <= w_r[k];
        end
        r_out_row <= w_crow;
        r_out_col <= w_ccol;
      end
      if (w_step) begin
        if (w_eof) begin
          r_row      <= '0;
          r_col      <= '0;
          r_state    <= StRun;
          r_in_ready <= 1'b1;
        end else begin
          if (w_last_col) begin
            r_col <= '0;
            r_row <= r_row + RIW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
          if (w_last_in) begin
            r_state    <= StFlush;
            r_in_ready <= 1'b0;
          end
        end
      end
    end
  end

  // Pixel storage, not reset: clamping guarantees stale entries are never shown.
  always_ff @(posedge clk) begin
    if (!rst && w_step) begin
      for (int k = 0; k < 3; k++) begin
        r_c1[k] <= r_c0[k];
        r_c0[k] <= w_new[k];
      end
      if (!w_flush) begin
        r_lb2[r_col] <= r_lb1[r_col];
        r_lb1[r_col] <= in_data;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_eof   = r_out_eof;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;
  assign p00       = r_win[0];
  assign p01       = r_win[1];
  assign p02       = r_win[2];
  assign p10       = r_win[3];
  assign p11       = r_win[4];
  assign p12       = r_win[5];
  assign p20       = r_win[6];
  assign p21       = r_win[7];
  assign p22       = r_win[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3
//   Directed bench for window_gen_3x3 on a 4x3 image. A frame-level model stores the
//   accepted pixels and derives each window from the clamp rule; every cycle the DUT
//   outputs are compared with it. Hand-computed windows pin the model's content.
module tb_window_gen_3x3;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       out_valid;
  logic       out_eof;
  logic [7:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic [1:0] out_row;
  logic [1:0] out_col;
  logic [71:0] dwin;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [7:0]  mimg [N];
  int          m_acc = 0;
  int          m_flush = 0;
  int          m_next = 0;
  logic        m_vld = 1'b0;
  logic        m_eof = 1'b0;
  logic [71:0] m_win = '0;
  int          m_row = 0;
  int          m_col = 0;

  // Observation
  int          fr = 0;
  int          lowcnt = 0;
  int          wcnt [8] = '{default: 0};
  int          low_run [8] = '{default: 0};
  logic [71:0] cap [8][H][W];
  logic [3:0]  eof_pos [8];

  window_gen_3x3 #(
    .IMG_W (W),
    .IMG_H (H),
    .DW    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .p00       (p00),
    .p01       (p01),
    .p02       (p02),
    .p10       (p10),
    .p11       (p11),
    .p12       (p12),
    .p20       (p20),
    .p21       (p21),
    .p22       (p22),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_eof   (out_eof)
  );

  assign dwin = {p00, p01, p02, p10, p11, p12, p20, p21, p22};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    int rr, cc;
    rr = (r < 0) ? 0 : ((r > H - 1) ? H - 1 : r);
    cc = (c < 0) ? 0 : ((c > W - 1) ? W - 1 : c);
    return mimg[rr * W + cc];
  endfunction

  task automatic emit(input int idx);
    int r, c;
    r = idx / W;
    c = idx % W;
    m_win = {pix(r-1, c-1), pix(r-1, c), pix(r-1, c+1),
             pix(r,   c-1), pix(r,   c), pix(r,   c+1),
             pix(r+1, c-1), pix(r+1, c), pix(r+1, c+1)};
    m_row = r;
    m_col = c;
    m_vld = 1'b1;
    m_eof = (idx == N - 1);
  endtask

  // Frame-level model: window i appears after input i+W+1 is accepted; after the last
  // pixel, the remaining W+1 windows follow on consecutive cycles with input blocked.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_acc = 0; m_flush = 0; m_vld = 1'b0; m_eof = 1'b0;
        m_win = '0; m_row = 0; m_col = 0;
      end else begin
        m_vld = 1'b0;
        m_eof = 1'b0;
        if (m_flush > 0) begin
          emit(m_next);
          m_next++;
          m_flush--;
          if (m_flush == 0) m_acc = 0;
        end else if (in_valid) begin
          mimg[m_acc] = in_data;
          if (m_acc >= W + 1) emit(m_acc - W - 1);
          m_acc++;
          if (m_acc == N) begin
            m_flush = W + 1;
            m_next  = N - W - 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus capture for the literal checks.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("out_valid", 72'(out_valid), 72'(m_vld));
      chk("in_ready",  72'(in_ready),  72'(m_flush == 0));
      chk("out_eof",   72'(out_eof),   72'(m_eof));
      chk("window",    dwin,           m_win);
      chk("out_row",   72'(out_row),   72'(m_row));
      chk("out_col",   72'(out_col),   72'(m_col));
      if (!in_ready) lowcnt++;
      else begin
        if (lowcnt > 0 && fr < 8) low_run[fr] = lowcnt;
        lowcnt = 0;
      end
      if (out_valid && fr < 8) begin
        cap[fr][out_row][out_col] = dwin;
        wcnt[fr]++;
        if (out_eof) begin
          eof_pos[fr] = {out_row, out_col};
          fr++;
        end
      end
    end
  end

  task automatic send_frame(input int base, input bit gap, input int npix);
    int  idx = 0;
    int  guard = 0;
    bit  v, rdy;
    while (idx < npix && guard < 2000) begin
      @(negedge clk);
      v        = gap ? ($urandom_range(1, 0) == 1) : 1'b1;
      in_valid = v;
      in_data  = 8'(base + 16 * (idx / W) + idx % W);
      rdy      = in_ready;
      @(posedge clk);
      if (v && rdy) idx++;
      guard++;
    end
    chk("send_done", 72'(idx), 72'(npix));
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (fr < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("frame_timeout", 72'(fr >= target), 72'(1));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_in_ready",  72'(in_ready),  72'(1));
    chk("rst_out_eof",   72'(out_eof),   72'(0));
    chk("rst_window",    dwin,           72'(0));
    chk("rst_row_col",   72'({out_row, out_col}), 72'(0));
    rst = 1'b0;

    // Two back-to-back frames, in_valid held high throughout.
    send_frame(0, 1'b0, N);
    send_frame(100, 1'b0, N);
    @(negedge clk);
    in_valid = 1'b0;
    wait_frames(2);
    chk("A_win00",  cap[0][0][0], {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd16, 8'd16, 8'd17});
    chk("A_win11",  cap[0][1][1], {8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34});
    chk("A_win23",  cap[0][2][3], {8'd18, 8'd19, 8'd19, 8'd34, 8'd35, 8'd35, 8'd34, 8'd35, 8'd35});
    chk("A_eof_pos", 72'(eof_pos[0]), 72'(4'b1011));
    chk("A_count",  72'(wcnt[0]), 72'(12));
    chk("A_ready_low", 72'(low_run[0]), 72'(5));
    chk("B_win00",  cap[1][0][0],
        {8'd100, 8'd100, 8'd101, 8'd100, 8'd100, 8'd101, 8'd116, 8'd116, 8'd117});
    chk("B_count",  72'(wcnt[1]), 72'(12));
    chk("B_ready_low", 72'(low_run[1]), 72'(5));

    // Random in_valid gaps: same windows as the gap-free frame.
    send_frame(0, 1'b1, N);
    @(negedge clk);
    in_valid = 1'b0;
    wait_frames(3);
    chk("G_count", 72'(wcnt[2]), 72'(12));
    chk("G_win11", cap[2][1][1], {8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34});
    chk("G_win23", cap[2][2][3],
        {8'd18, 8'd19, 8'd19, 8'd34, 8'd35, 8'd35, 8'd34, 8'd35, 8'd35});

    // Reset after 7 pixels, then a full frame.
    send_frame(50, 1'b0, 7);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 72'(out_valid), 72'(0));
    chk("rst_mid_ready", 72'(in_ready), 72'(1));
    rst = 1'b0;
    wcnt[3] = 0;
    send_frame(0, 1'b0, N);
    @(negedge clk);
    in_valid = 1'b0;
    wait_frames(4);
    chk("R_count", 72'(wcnt[3]), 72'(12));
    chk("R_win00", cap[3][0][0], {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd16, 8'd16, 8'd17});
    chk("R_win23", cap[3][2][3],
        {8'd18, 8'd19, 8'd19, 8'd34, 8'd35, 8'd35, 8'd34, 8'd35, 8'd35});

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 neighbourhood generator that sits directly upstream of the Gaussian blur stage. It accepts a raster-order grayscale pixel stream and presents, one window per cycle, the nine pixels p00..p22 centred on each image pixel. Image borders use replicate (clamp-to-edge) padding, so every pixel yields exactly one window. Two internal line buffers hold the previous rows; a flush sequence drains the final windows after the last input pixel.

## Interface
- IMG_W, 415, image width in pixels (>= 2)
- IMG_H, 738, image height in pixels (>= 2)
- DW, 8, pixel width in bits
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data holds a pixel
- in_ready  out  1  block can accept; transfer when in_valid && in_ready
- in_data  in  DW  pixel, raster order (row-major, col 0 first)
- out_valid  out  1  p00..p22, out_row and out_col hold a window this cycle
- p00,p01,p02,p10,p11,p12,p20,p21,p22  out  DW each  window; pRC = pixel at (row+R-1, col+C-1), clamped
- out_row  out  clog2(IMG_H)  centre row of current window
- out_col  out  clog2(IMG_W)  centre column of current window
- out_eof  out  1  high with out_valid on the last window of a frame (IMG_H-1, IMG_W-1)

## Operation
- Frame = IMG_H*IMG_W accepted pixels; frame starts at the first accepted pixel after reset or after the previous frame's flush completes.
- Input row/column counters advance only on an accepted transfer; column wraps at IMG_W-1 to 0 and increments the row.
- Window content for centre (r,c): pRC = img[clamp(r+R-1, 0, IMG_H-1)][clamp(c+C-1, 0, IMG_W-1)].
- Windows are emitted in raster order of centre, exactly IMG_H*IMG_W per frame, no duplicates or gaps.
- Window i (linear index r*IMG_W+c) is emitted once input linear index i+IMG_W+1 is accepted; input index i+IMG_W+1 is the latest pixel the clamped window can need.
- States: RUN (in_ready=1, windows triggered by accepted inputs) and FLUSH (in_ready=0, windows issued autonomously).
- RUN -> FLUSH on acceptance of the last pixel (IMG_H-1, IMG_W-1).
- FLUSH emits the remaining IMG_W+1 windows on consecutive cycles. Pixels beyond the frame are never read; clamping supplies them.
- FLUSH -> RUN after the window with out_eof is emitted. Output counters and input counters return to 0.
- No output backpressure: the downstream stage accepts a window every cycle.
- When out_valid=0, p*, out_row and out_col hold their last values. out_eof=0.
- Line buffer contents are not cleared between frames. Clamping ensures stale data is never used.

## Timing
- Reset values: out_valid=0, out_eof=0, p00..p22=0, out_row=0, out_col=0, in_ready=1, state RUN, all counters 0. Line buffer RAM is not reset.
- in_data/in_valid are ignored while rst=1.
- Reset asserted mid-frame or mid-flush: the next cycle has out_valid=0. The partial frame is discarded, and the next accepted pixel is (0,0) of a new frame.
- Outputs are registered. Window i is valid in the cycle after the clock edge that accepts input i+IMG_W+1.
- A gap in in_valid during RUN produces a matching gap in out_valid. There is no other effect.
- The first IMG_W+1 accepted pixels of a frame produce no output.
- In FLUSH, out_valid=1 for exactly IMG_W+1 consecutive cycles. in_ready falls in the cycle after the last pixel is accepted and rises in the cycle after the out_eof window.
- Back-to-back frames: pixel 0 of the next frame is acceptable in the cycle after out_eof. Maximum throughput is one window per cycle in steady state.

## Test plan
- IMG_W=4, IMG_H=3, in_data=16*r+c, in_valid held high -> the first out_valid occurs 1 cycle after the 6th accepted pixel, with window (0,0) = p00..p22 = 0,0,1,0,0,1,16,16,17.
- Same frame, corner (2,3) -> p00..p22 = 18,19,19,34,35,35,34,35,35, with out_eof=1. Exactly 12 windows are emitted. in_ready=0 for exactly 5 cycles, then returns to 1.
- Interior centre (1,1) -> p00..p22 = 0,1,2,16,17,18,32,33,34, out_row=1, out_col=1.
- Random in_valid gaps (about 50% duty) on a 4x3 frame -> the window sequence is identical to the gap-free run. in_valid asserted while in_ready=0 is not accepted.
- Two back-to-back 4x3 frames, second frame with in_data=100+16*r+c -> the second frame's (0,0) window is 100,100,101,100,100,101,116,116,117. No stale first-frame values appear.
- rst pulsed after 7 pixels of a frame -> out_valid=0 the next cycle. The subsequent full frame produces exactly 12 correct windows.
